// File: rtl/axi4l_wb_master_bridge_if.sv
// Bus interfaces for the AXI4-Lite to wishbone master bridge.
//   axi4l_if : AXI4-Lite channel bundle; the bridge connects through the slave modport.
//   wb_if    : wishbone classic bundle; the bridge connects through the master modport.
// Signal suffixes on wb_if (_o/_i) are from the wishbone master's point of view.

interface axi4l_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic                  aw_valid;
   logic                  aw_ready;
   logic [31:0]           w_data;
   logic [3:0]            w_strb;
   logic                  w_valid;
   logic                  w_ready;
   logic [1:0]            b_resp;
   logic                  b_valid;
   logic                  b_ready;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic                  ar_valid;
   logic                  ar_ready;
   logic [31:0]           r_data;
   logic [1:0]            r_resp;
   logic                  r_valid;
   logic                  r_ready;

   modport master (
      output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_valid, r_ready,
      input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
   );

   modport slave (
      input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_valid, r_ready,
      output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
   );
endinterface

interface wb_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] wb_adr_o;
   logic [31:0]           wb_dat_o;
   logic [3:0]            wb_sel_o;
   logic                  wb_we_o;
   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic [31:0]           wb_dat_i;
   logic                  wb_ack_i;
   logic                  wb_err_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );
endinterface

// File: rtl/axi4l_wb_master_bridge.sv
// AXI4-Lite slave to single-outstanding wishbone classic master bridge.
// Each AXI read or write becomes exactly one wishbone cycle; reads and writes
// are round-robin arbitrated when both are pending, wishbone err maps to SLVERR.
// Optional bus-timeout watchdog: define AXI4L_WB_TIMEOUT_EN to compile it in
// (aborts with DECERR after TIMEOUT_CYCLES cycles without ack/err).

module axi4l_wb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic   clk_i,
   input  logic   rst_i,
   axi4l_if.slave axi,
   wb_if.master   wb,
   output logic   timeout_o
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WB_WR,
      WB_RD,
      BRESP,
      RRESP
   } state_t;

   state_t state_q;
   state_t state_d;

   // Round-robin pointer: 1 means a write wins when both types are pending.
   logic pref_wr_q;

   logic wr_pend;
   logic rd_pend;
   logic in_idle;
   logic wr_acc;
   logic rd_acc;
   logic wb_active;
   logic wb_term;
   logic to_hit;

   // ------------------------------------------------------------------
   // Arbitration: AW and W must both be valid for a write to be pending.
   // ------------------------------------------------------------------
   assign wr_pend   = axi.aw_valid && axi.w_valid;
   assign rd_pend   = axi.ar_valid;
   assign in_idle   = (state_q == IDLE) && !rst_i;
   assign wr_acc    = in_idle && wr_pend && (pref_wr_q || !rd_pend);
   assign rd_acc    = in_idle && rd_pend && (!pref_wr_q || !wr_pend);
   assign wb_active = (state_q == WB_WR) || (state_q == WB_RD);
   assign wb_term   = wb_active && (wb.wb_ack_i || wb.wb_err_i);

`ifdef AXI4L_WB_TIMEOUT_EN
   localparam int CNT_RAW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_WIDTH = (CNT_RAW < 8) ? 8 : CNT_RAW;

   logic [CNT_WIDTH-1:0] to_cnt_q;

   // Watchdog counter: cleared on accept, counts every cycle a wishbone cycle is open.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_cnt_q <= '0;
      end else if (wr_acc || rd_acc) begin
         to_cnt_q <= '0;
      end else if (wb_active) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   // A real ack/err in the expiry cycle takes precedence over the abort.
   assign to_hit = wb_active && !wb.wb_ack_i && !wb.wb_err_i &&
                   (to_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
   // Watchdog compiled out: never aborts (comparison is constant false
   // for any legal TIMEOUT_CYCLES and keeps the parameter referenced).
   assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_acc) begin
               state_d = WB_WR;
            end else if (rd_acc) begin
               state_d = WB_RD;
            end
         end
         WB_WR: begin
            if (wb_term || to_hit) begin
               state_d = BRESP;
            end
         end
         WB_RD: begin
            if (wb_term || to_hit) begin
               state_d = RRESP;
            end
         end
         BRESP: begin
            if (axi.b_ready) begin
               state_d = IDLE;
            end
         end
         RRESP: begin
            if (axi.r_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State-decoded outputs: readies only in IDLE, cyc/stb only while a wishbone cycle is open.
   always_comb begin
      axi.aw_ready = 1'b0;
      axi.w_ready  = 1'b0;
      axi.ar_ready = 1'b0;
      axi.b_valid  = 1'b0;
      axi.r_valid  = 1'b0;
      wb.wb_cyc_o  = 1'b0;
      wb.wb_stb_o  = 1'b0;
      case (state_q)
         IDLE: begin
            axi.aw_ready = wr_acc;
            axi.w_ready  = wr_acc;
            axi.ar_ready = rd_acc;
         end
         WB_WR, WB_RD: begin
            wb.wb_cyc_o = 1'b1;
            wb.wb_stb_o = 1'b1;
         end
         BRESP: axi.b_valid = 1'b1;
         RRESP: axi.r_valid = 1'b1;
         default: ;
      endcase
   end

   // Request capture: address, data, select and direction are latched on accept
   // and held for the whole wishbone cycle; the arbitration pointer flips to the other type.
   always_ff @(posedge clk_i) begin
      // NOTE: datapath registers are reset too, since every output must read 0 after reset.
      if (rst_i) begin
         wb.wb_adr_o <= '0;
         wb.wb_dat_o <= '0;
         wb.wb_sel_o <= '0;
         wb.wb_we_o  <= 1'b0;
         pref_wr_q   <= 1'b1;
      end else if (wr_acc) begin
         wb.wb_adr_o <= axi.aw_addr;
         wb.wb_dat_o <= axi.w_data;
         wb.wb_sel_o <= axi.w_strb;
         wb.wb_we_o  <= 1'b1;
         pref_wr_q   <= 1'b0;
      end else if (rd_acc) begin
         wb.wb_adr_o <= axi.ar_addr;
         wb.wb_sel_o <= {STRB_WIDTH{1'b1}};
         wb.wb_we_o  <= 1'b0;
         pref_wr_q   <= 1'b1;
      end
   end

   // Response capture: err beats ack, ack beats timeout; values hold through the AXI response phase.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         axi.b_resp <= RESP_OKAY;
         axi.r_resp <= RESP_OKAY;
         axi.r_data <= '0;
         timeout_o  <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         if (state_q == WB_WR) begin
            if (wb.wb_err_i) begin
               axi.b_resp <= RESP_SLVERR;
            end else if (wb.wb_ack_i) begin
               axi.b_resp <= RESP_OKAY;
            end else if (to_hit) begin
               axi.b_resp <= RESP_DECERR;
               timeout_o  <= 1'b1;
            end
         end
         if (state_q == WB_RD) begin
            if (wb.wb_err_i) begin
               axi.r_resp <= RESP_SLVERR;
               axi.r_data <= '0;
            end else if (wb.wb_ack_i) begin
               axi.r_resp <= RESP_OKAY;
               axi.r_data <= wb.wb_dat_i;
            end else if (to_hit) begin
               axi.r_resp <= RESP_DECERR;
               axi.r_data <= '0;
               timeout_o  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi4l_wb_master_bridge.sv
// Self-checking bench for axi4l_wb_master_bridge: directed AXI transactions,
// a scoreboard queue of expected responses, and a configurable wishbone slave.
// Define AXI4L_WB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).

`timescale 1ns/1ps

module tb_axi4l_wb_master_bridge;

   localparam int AW        = 32;
   localparam int TO_CYCLES = 8;
   localparam int BUDGET    = 60;

   typedef struct packed {
      logic        is_wr;
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   typedef enum logic [1:0] {S_ACK, S_ERR, S_BOTH, S_NEVER} smode_t;

   logic clk_i = 1'b0;
   logic rst_i;
   logic timeout_o;

   axi4l_if #(.ADDR_WIDTH(AW)) axi ();
   wb_if    #(.ADDR_WIDTH(AW)) wb ();

   axi4l_wb_master_bridge #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(TO_CYCLES)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .axi      (axi),
      .wb       (wb),
      .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- wishbone slave model ----------------
   smode_t      s_mode  = S_ACK;
   int          s_waits = 0;
   logic [31:0] s_rdata = '0;
   logic [7:0]  s_cnt   = '0;
   logic        s_hit;

   assign s_hit       = wb.wb_cyc_o && wb.wb_stb_o && (int'(s_cnt) == s_waits);
   assign wb.wb_ack_i = s_hit && (s_mode == S_ACK || s_mode == S_BOTH);
   assign wb.wb_err_i = s_hit && (s_mode == S_ERR || s_mode == S_BOTH);
   assign wb.wb_dat_i = s_rdata;

   always @(posedge clk_i) begin
      if (wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_ack_i && !wb.wb_err_i) s_cnt <= s_cnt + 8'd1;
      else s_cnt <= '0;
   end

   // ---------------- bus monitor ----------------
   int          cyc_total      = 0;
   int          we_total       = 0;
   int          to_total       = 0;
   int          overlap_total  = 0;
   int          unstable_total = 0;
   logic [AW-1:0] mon_adr = '0;
   logic [31:0] mon_dat = '0;
   logic [3:0]  mon_sel = '0;
   logic        mon_we  = 1'b0;
   logic        prev_cyc = 1'b0;
   logic [AW+31+4+1:0] prev_bus = '0;
   logic [AW+31+4+1:0] cur_bus;

   assign cur_bus = {wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o, wb.wb_we_o, wb.wb_stb_o};

   always @(negedge clk_i) begin
      if (wb.wb_cyc_o) begin
         cyc_total <= cyc_total + 1;
         if (wb.wb_we_o) we_total <= we_total + 1;
         if (prev_cyc && (cur_bus != prev_bus)) unstable_total <= unstable_total + 1;
         mon_adr <= wb.wb_adr_o;
         mon_dat <= wb.wb_dat_o;
         mon_sel <= wb.wb_sel_o;
         mon_we  <= wb.wb_we_o;
      end
      prev_cyc <= wb.wb_cyc_o;
      prev_bus <= cur_bus;
      if (timeout_o) to_total <= to_total + 1;
      if ((axi.aw_ready || axi.w_ready) && axi.ar_ready) overlap_total <= overlap_total + 1;
      if (axi.aw_ready != axi.w_ready) overlap_total <= overlap_total + 1;
   end

   // ---------------- checking helpers ----------------
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] out_vec();
      return 128'({axi.aw_ready, axi.w_ready, axi.b_resp, axi.b_valid, axi.ar_ready,
                   axi.r_data, axi.r_resp, axi.r_valid, wb.wb_adr_o, wb.wb_dat_o,
                   wb.wb_sel_o, wb.wb_we_o, wb.wb_cyc_o, wb.wb_stb_o, timeout_o});
   endfunction

   task automatic expect_rsp(input logic w, input logic [1:0] r, input logic [31:0] d);
      exp_t e;
      e.is_wr = w;
      e.resp  = r;
      e.data  = d;
      sb.push_back(e);
   endtask

   // Called #1 after a posedge; returns #1 after the accept edge.
   task automatic drive_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      bit got = 1'b0;
      axi.aw_addr  = a;
      axi.w_data   = d;
      axi.w_strb   = s;
      axi.aw_valid = 1'b1;
      axi.w_valid  = 1'b1;
      for (int i = 0; i < BUDGET && !got; i++) begin
         @(negedge clk_i);
         got = axi.aw_ready && axi.w_ready;
      end
      check("wr_accept", 128'(got), 128'(1));
      @(posedge clk_i); #1;
      axi.aw_valid = 1'b0;
      axi.w_valid  = 1'b0;
   endtask

   task automatic drive_read(input logic [AW-1:0] a);
      bit got = 1'b0;
      axi.ar_addr  = a;
      axi.ar_valid = 1'b1;
      for (int i = 0; i < BUDGET && !got; i++) begin
         @(negedge clk_i);
         got = axi.ar_ready;
      end
      check("rd_accept", 128'(got), 128'(1));
      @(posedge clk_i); #1;
      axi.ar_valid = 1'b0;
   endtask

   // Waits for a response, pops the scoreboard and compares; optionally holds
   // ready low for 'hold' cycles checking the response stays put; then handshakes.
   task automatic collect(input string tag, input int hold, output int lat);
      exp_t        e;
      bit          got = 1'b0;
      logic [1:0]  rsp;
      lat = 0;
      for (int i = 0; i < BUDGET && !got; i++) begin
         @(negedge clk_i);
         lat++;
         got = axi.b_valid || axi.r_valid;
      end
      check({tag, "_valid"}, 128'(got), 128'(1));
      if (got) begin
         check({tag, "_sb"}, 128'(sb.size() > 0), 128'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_type"}, 128'(axi.b_valid), 128'(e.is_wr));
            rsp = e.is_wr ? axi.b_resp : axi.r_resp;
            check({tag, "_resp"}, 128'(rsp), 128'(e.resp));
            if (!e.is_wr) check({tag, "_rdata"}, 128'(axi.r_data), 128'(e.data));
            for (int h = 0; h < hold; h++) begin
               @(negedge clk_i);
               check({tag, "_hold"}, 128'({axi.r_valid, axi.r_resp, axi.r_data}),
                     128'({1'b1, e.resp, e.data}));
            end
         end
         axi.b_ready = 1'b1;
         axi.r_ready = 1'b1;
         @(posedge clk_i); #1;
         axi.b_ready = 1'b0;
         axi.r_ready = 1'b0;
      end
   endtask

   // Hard stop in case something outside the bounded waits stalls.
   initial begin
      #400000;
      $display("FAIL global_timeout observed=stalled required=finish");
      $fatal(1, "bench stalled");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int c0;
      int w0;
      int t0;
      bit rv_seen;
      bit got;
      bit exp_wr;

      axi.aw_addr = '0; axi.aw_valid = 1'b0; axi.w_data = '0; axi.w_strb = '0;
      axi.w_valid = 1'b0; axi.b_ready = 1'b0; axi.ar_addr = '0; axi.ar_valid = 1'b0;
      axi.r_ready = 1'b0;
      rst_i = 1'b1;

      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_outputs", out_vec(), 128'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // Write with two wait states
      s_mode = S_ACK; s_waits = 2;
      c0 = cyc_total; w0 = we_total;
      expect_rsp(1'b1, 2'b00, 32'h0);
      drive_write(32'h0000_0010, 32'hA5A5_1234, 4'b0011);
      collect("wr_basic", 0, lat);
      check("wr_latency", 128'(lat), 128'(4));
      check("wr_cyc_cycles", 128'(cyc_total - c0), 128'(3));
      check("wr_we_cycles", 128'(we_total - w0), 128'(3));
      check("wr_adr", 128'(mon_adr), 128'(32'h10));
      check("wr_sel", 128'(mon_sel), 128'(4'b0011));
      check("wr_dat", 128'(mon_dat), 128'(32'hA5A5_1234));

      // Zero-wait read, response held with r_ready low for 4 cycles
      s_mode = S_ACK; s_waits = 0; s_rdata = 32'hCAFE_F00D;
      c0 = cyc_total;
      expect_rsp(1'b0, 2'b00, 32'hCAFE_F00D);
      drive_read(32'h0000_0014);
      collect("rd_basic", 4, lat);
      check("rd_latency", 128'(lat), 128'(2));
      check("rd_cyc_cycles", 128'(cyc_total - c0), 128'(1));
      check("rd_adr_sel_we", 128'({mon_adr, mon_sel, mon_we}), 128'({32'h14, 4'hF, 1'b0}));

      // Error mapping
      s_mode = S_ERR; s_waits = 1; s_rdata = 32'hDEAD_BEEF;
      expect_rsp(1'b1, 2'b10, 32'h0);
      drive_write(32'h0000_0020, 32'h1111_2222, 4'hF);
      collect("wr_err", 0, lat);
      expect_rsp(1'b0, 2'b10, 32'h0);
      drive_read(32'h0000_0024);
      collect("rd_err", 0, lat);
      s_mode = S_BOTH; s_waits = 0;
      expect_rsp(1'b0, 2'b10, 32'h0);
      drive_read(32'h0000_0028);
      collect("rd_ack_err", 0, lat);

      // Arbitration: both types kept pending; the last served was a read, so write goes first
      s_mode = S_ACK; s_waits = 0; s_rdata = 32'h1234_5678;
      axi.aw_addr = 32'h40; axi.w_data = 32'h5555_AAAA; axi.w_strb = 4'hF; axi.ar_addr = 32'h44;
      axi.aw_valid = 1'b1; axi.w_valid = 1'b1; axi.ar_valid = 1'b1;
      for (int n = 0; n < 4; n++) begin
         got = 1'b0;
         exp_wr = (n % 2 == 0);
         for (int i = 0; i < BUDGET && !got; i++) begin
            @(negedge clk_i);
            got = axi.aw_ready || axi.ar_ready;
         end
         check("arb_accept", 128'(got), 128'(1));
         check("arb_order", 128'(axi.aw_ready), 128'(exp_wr));
         expect_rsp(exp_wr, 2'b00, 32'h1234_5678);
         @(posedge clk_i); #1;
         if (n == 3) begin
            axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
         end
         collect("arb", 0, lat);
      end

      // Reset during a read wait: cycle dropped, no response
      s_mode = S_ACK; s_waits = 10;
      drive_read(32'h0000_0030);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      check("rst_mid_outputs", out_vec(), 128'd0);
      rst_i = 1'b0;
      rv_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         rv_seen = rv_seen | axi.r_valid | wb.wb_cyc_o;
      end
      check("rst_no_response", 128'(rv_seen), 128'(0));
      @(posedge clk_i); #1;
      s_waits = 0;
      expect_rsp(1'b1, 2'b00, 32'h0);
      drive_write(32'h0000_0034, 32'h0BAD_F00D, 4'b1100);
      collect("post_rst_wr", 0, lat);

`ifdef AXI4L_WB_TIMEOUT_EN
      // Slave never answers: abort after TIMEOUT_CYCLES+1 cycles of cyc
      s_mode = S_NEVER;
      c0 = cyc_total; t0 = to_total;
      expect_rsp(1'b0, 2'b11, 32'h0);
      drive_read(32'h0000_0050);
      collect("to_abort", 0, lat);
      check("to_cyc_cycles", 128'(cyc_total - c0), 128'(TO_CYCLES + 1));
      check("to_pulses", 128'(to_total - t0), 128'(1));
      // Ack in the expiry cycle wins
      s_mode = S_ACK; s_waits = TO_CYCLES; s_rdata = 32'h7777_0001;
      c0 = cyc_total; t0 = to_total;
      expect_rsp(1'b0, 2'b00, 32'h7777_0001);
      drive_read(32'h0000_0054);
      collect("to_ack_last", 0, lat);
      check("to_ack_cyc_cycles", 128'(cyc_total - c0), 128'(TO_CYCLES + 1));
      check("to_ack_no_pulse", 128'(to_total - t0), 128'(0));
`else
      check("to_tied_low", 128'(to_total), 128'(0));
`endif

      repeat (2) @(negedge clk_i);
      check("sb_drained", 128'(sb.size()), 128'(0));
      check("ready_overlap", 128'(overlap_total), 128'(0));
      check("wb_hold_stable", 128'(unstable_total), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4l_wb_master_bridge.md
Name: axi4l_wb_master_bridge

Overview:
- Upstream stage of the wishbone DSP cores: AXI4-Lite slave on one side, single-outstanding wishbone classic master on the other.
- Converts each AXI read or write into exactly one wishbone cycle and returns an AXI response.
- Adds read/write arbitration, wishbone error mapping and an optional bus-timeout watchdog.
- Drives the wb_* slave ports of a core such as the IIR filter directly.

Parameters:
- ADDR_WIDTH, 32: AXI and wishbone address width.
- DATA_WIDTH, 32: data width; fixed at 32, so strobe/sel width is 4.
- TIMEOUT_CYCLES, 255: wishbone cycles waited for ack/err before abort; used only when the optional feature is compiled in; must be at least 1.

Ports:
- clk_i  in  1  clock, shared by AXI and wishbone sides
- rst_i  in  1  synchronous active-high reset
- aw_addr  in  ADDR_WIDTH  AXI write address
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address ready
- w_data  in  32  write data
- w_strb  in  4  write byte strobes
- w_valid  in  1  write data valid
- w_ready  out  1  write data ready
- b_resp  out  2  write response
- b_valid  out  1  write response valid
- b_ready  in  1  write response ready
- ar_addr  in  ADDR_WIDTH  read address
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address ready
- r_data  out  32  read data
- r_resp  out  2  read response
- r_valid  out  1  read response valid
- r_ready  in  1  read response ready
- wb_adr_o  out  ADDR_WIDTH  wishbone address
- wb_dat_o  out  32  wishbone write data
- wb_sel_o  out  4  wishbone byte select
- wb_we_o  out  1  wishbone write enable
- wb_cyc_o  out  1  wishbone cycle
- wb_stb_o  out  1  wishbone strobe
- wb_dat_i  in  32  wishbone read data
- wb_ack_i  in  1  wishbone acknowledge
- wb_err_i  in  1  wishbone error
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: all outputs are 0 after the first clk_i edge with rst_i high, including r_data, b_resp, r_resp and all wb_* outputs.
  - FSM returns to IDLE.
  - An in-flight wishbone cycle is dropped (cyc/stb low) that same edge, with no AXI response issued.
  - Arbitration pointer resets to "write preferred".
- FSM states: IDLE, WB_WR, WB_RD, BRESP, RRESP.
- IDLE:
  - aw_ready = w_ready = (aw_valid & w_valid & write selected).
  - ar_ready = (ar_valid & read selected).
  - AW and W are accepted only together, in the same cycle.
  - Write is selected when only a write is pending; read is selected when only a read is pending.
  - When both are pending, the type opposite to the last served type is selected (round-robin). The pointer updates on each accept.
  - Ready outputs are combinational from IDLE, valids and pointer; they are high only in IDLE.
- Accept edge:
  - The address is registered to wb_adr_o.
  - On a write, w_data is registered to wb_dat_o, w_strb to wb_sel_o, and wb_we_o is set to 1.
  - On a read, wb_sel_o is set to 4'hF and wb_we_o to 0.
  - wb_cyc_o and wb_stb_o go high from the next cycle. Latency from accept to cyc is 1 clock.
- WB_WR / WB_RD: cyc, stb, adr, dat, sel and we are held stable until wb_ack_i or wb_err_i is sampled high.
  - On ack: cyc/stb drop on that edge. Response is OKAY (2'b00). For reads, wb_dat_i is captured into r_data.
  - On err (err has priority if ack and err are both high): response is SLVERR (2'b10). r_data = 0.
  - Next state is BRESP or RRESP.
- BRESP / RRESP: b_valid / r_valid is high and stable, with resp and data held, until the matching ready is high. Then return to IDLE.
  - The next request can be accepted in the cycle after the handshake.
- Minimum transaction, zero-wait slave: accept at cycle 0, cyc at cycle 1, ack at cycle 1, valid at cycle 2, so 3 cycles minimum.
- Only one transaction is outstanding at a time. No pipelining.
- wb_ack_i and wb_err_i outside an active cycle are ignored.

Optional Feature:
- Macro: AXI4L_WB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (width clog2(TIMEOUT_CYCLES+1)) clears on each accept and increments every cycle in WB_WR/WB_RD.
  - When the counter equals TIMEOUT_CYCLES with no ack/err that cycle, cyc/stb drop, the response is DECERR (2'b11) with r_data = 0, and timeout_o pulses for 1 cycle.
  - Ack/err on the same cycle as expiry wins over the timeout.
- Undefined: no counter; the bridge waits indefinitely; timeout_o tied 0.

Test Plan:
- Write to 0x0000_0010 with data 0xA5A5_1234 and strobe 4'b0011; slave acks after 2 waits -> wb_adr_o 0x10, wb_sel_o 4'b0011, wb_we_o 1 for 3 cycles, then b_valid with b_resp 00.
- Read from 0x14 with a zero-wait slave returning 0xCAFE_F00D -> r_valid 2 cycles after accept, r_data 0xCAFEF00D, r_resp 00; hold r_ready low 4 cycles -> r_data and r_valid stay stable.
- Simultaneous AW+W and AR valid, repeated 4 times -> served order write, read, write, read; ready outputs never high in two channels at once.
- Slave asserts wb_err_i on a write and on a read -> b_resp 10 and r_resp 10 with r_data 0; ack+err in the same cycle -> 10.
- With AXI4L_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 9 cycles high, timeout_o one pulse, r_resp 11; ack on the final cycle -> r_resp 00, no pulse.
- rst_i asserted during WB_RD wait -> the next edge gives cyc/stb 0, no r_valid, outputs 0; a following write completes normally with b_resp 00.
